// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   Deserializer for the team serial link. Detects a start bit on an idle-high
//   line, samples each bit at mid-period, shifts in WIDTH data bits LSB first,
//   checks an optional even parity bit and the stop bit. It then presents the
//   word with a valid/read handshake.
//
// Parameters
//   WIDTH      data bits per frame (>= 1)
//   BIT_CYCLES clock cycles per serial bit (>= 1)
//   PARITY_EN  1 = even parity bit follows the data bits, 0 = none
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   serial_in    serial line, idle high, already synchronous to clk
//   read         consumer acknowledge for the held word
//   parallel_out last accepted word, bit 0 = first received data bit
//   valid        a word is held and not yet read
//   parity_error parity status of the held word (1 = mismatch)
//   frame_error  one-cycle pulse when the stop bit is sampled as 0
//   overrun      sticky, a held word was overwritten before being read
//   busy         receiver is inside a frame

module serial_frame_receiver #(
    parameter int WIDTH      = 4,
    parameter int BIT_CYCLES = 4,
    parameter int PARITY_EN  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             read,
    output logic [WIDTH-1:0] parallel_out,
    output logic             valid,
    output logic             parity_error,
    output logic             frame_error,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = $clog2(BIT_CYCLES) + 1;
    localparam int BW = $clog2(WIDTH) + 1;
    localparam int H  = BIT_CYCLES / 2;

    localparam logic [CW-1:0] HALF     = CW'(H);
    localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);
    // The counter holds the number of cycles since the start edge, modulo
    // BIT_CYCLES. Every sample point therefore falls on cyc_cnt == HALF.
    localparam logic [CW-1:0] FIRST    = CW'((BIT_CYCLES == 1) ? 0 : 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    logic [2:0]       state;
    logic [CW-1:0]    cyc_cnt;
    logic [CW-1:0]    cyc_next;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shifter;
    logic [WIDTH-1:0] shift_next;
    logic             par_acc;
    logic             sample;

    assign sample   = (cyc_cnt == HALF);
    assign cyc_next = (cyc_cnt == LAST_CYC) ? '0 : cyc_cnt + CW'(1);
    assign busy     = (state != S_IDLE);

    // New bit enters at the MSB so that the first received bit ends in bit 0.
    always_comb begin
        shift_next            = shifter >> 1;
        shift_next[WIDTH-1]   = serial_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cyc_cnt      <= '0;
            bit_cnt      <= '0;
            shifter      <= '0;
            par_acc      <= 1'b0;
            parallel_out <= '0;
            valid        <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            frame_error <= 1'b0;

            if (read && valid) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end

            if (state != S_IDLE)
                cyc_cnt <= cyc_next;

            case (state)
                S_IDLE: begin
                    if (!serial_in) begin
                        // With one cycle per bit the start confirm coincides
                        // with detection, so go straight to data.
                        state   <= (H == 0) ? S_DATA : S_START;
                        cyc_cnt <= FIRST;
                        bit_cnt <= '0;
                        par_acc <= 1'b0;
                    end
                end

                S_START: begin
                    if (sample)
                        state <= serial_in ? S_IDLE : S_DATA;
                end

                S_DATA: begin
                    if (sample) begin
                        shifter <= shift_next;
                        par_acc <= par_acc ^ serial_in;
                        if (bit_cnt == LAST_BIT)
                            state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        else
                            bit_cnt <= bit_cnt + BW'(1);
                    end
                end

                S_PARITY: begin
                    if (sample) begin
                        par_acc <= par_acc ^ serial_in;
                        state   <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (sample) begin
                        if (serial_in) begin
                            // Completion overrides a same-edge read: the new
                            // word stays valid and overrun only reflects an
                            // unread word being replaced.
                            parallel_out <= shifter;
                            valid        <= 1'b1;
                            parity_error <= (PARITY_EN != 0) && par_acc;
                            overrun      <= valid && !read;
                            state        <= S_IDLE;
                        end else begin
                            frame_error  <= 1'b1;
                            state        <= S_WAIT_IDLE;
                        end
                    end
                end

                S_WAIT_IDLE: begin
                    if (serial_in)
                        state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

- Receiving end of the team's serial link: the deserializer paired with the parallel-load shift register transmitter.
- Watches a single-bit line, detects start bits and samples each bit at mid-period.
- Shifts in a WIDTH-bit word LSB first, checks optional even parity and the stop bit.
- Presents the word on a parallel port with a valid/read handshake and error/overrun flags.

## Interface
- WIDTH, 4, data bits per frame (≥1)
- BIT_CYCLES, 4, clock cycles per serial bit (≥1)
- PARITY_EN, 1, 1 = even parity bit after the data bits; 0 = no parity bit
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- serial_in  input  1  serial line; idle high
- read  input  1  consumer acknowledges the held word; meaningful only while valid=1
- parallel_out  output  WIDTH  last accepted data word, bit 0 = first received data bit
- valid  output  1  a word is held in parallel_out and not yet read
- parity_error  output  1  parity status of the held word (1 = mismatch)
- frame_error  output  1  one-cycle pulse: stop bit sampled as 0
- overrun  output  1  sticky: a word was overwritten before being read
- busy  output  1  receiver is inside a frame (state ≠ IDLE)

## Operation
- Frame: start bit 0, WIDTH data bits LSB first, parity bit (if PARITY_EN), stop bit 1.
- Let H = floor(BIT_CYCLES/2) and B = BIT_CYCLES. Cycle 0 is the first cycle in IDLE where serial_in=0.
- Sample points:
  - start confirm at cycle H
  - data bit i (0..WIDTH-1) at H+(i+1)·B
  - parity at H+(WIDTH+1)·B
  - stop at H+(WIDTH+1+PARITY_EN)·B
- States and transitions:
  - IDLE: serial_in=0 → START; bit counter and cycle counter cleared.
  - START: at the confirm sample, serial_in=1 → IDLE (glitch rejected, no flags); serial_in=0 → DATA.
  - DATA: shift one bit per sample point into bit WIDTH-1 of the shifter, shifting right. After bit WIDTH-1 → PARITY if PARITY_EN, else STOP.
  - PARITY: sample the parity bit. Mismatch when XOR(data bits, parity bit)=1. → STOP.
  - STOP, serial_in=1: load parallel_out, set valid=1, load parity_error → IDLE.
  - STOP, serial_in=0: data discarded, parallel_out/valid/parity_error unchanged, frame_error=1 for one cycle → WAIT_IDLE.
  - WAIT_IDLE: stay until serial_in=1 → IDLE. This handles a held-low line (break).
- Handshake:
  - read=1 while valid=1 clears valid and overrun at that edge.
  - read while valid=0 has no effect.
- Overrun:
  - A frame completes while valid=1 and read=0: the new word overwrites parallel_out, valid stays 1, overrun is set.
  - Frame completion and read=1 on the same edge: the new word loads, valid stays 1, overrun is cleared/not set.
- Counters: cycle counter ceil(log2(BIT_CYCLES))+1 bits, wraps at B-1. Bit counter ceil(log2(WIDTH))+1 bits.

## Timing
- Reset values: parallel_out=0, valid=0, parity_error=0, frame_error=0, overrun=0, busy=0; state IDLE; counters 0. Reset takes priority over all other events.
- Reset asserted mid-frame aborts the frame and delivers nothing. After reset deasserts, the receiver needs a fresh falling edge of the line (serial_in=0 while in IDLE).
- Output latency: outputs update on the edge that samples the stop bit, so they are visible from cycle H+(WIDTH+1+PARITY_EN)·B+1.
- The receiver returns to IDLE on the stop-sample edge. The next start bit may be detected the following cycle, so back-to-back frames with a one-bit stop are supported.
- busy rises the cycle after start detection and falls after the stop sample (or when leaving WAIT_IDLE).
- serial_in is sampled directly. Synchronization to clk is the caller's responsibility.

## Test plan
- Defaults, send 4'b1001 (line: 0,1,0,0,1,0,1; each bit held 4 cycles) → at cycle 27: parallel_out=4'b1001, valid=1, parity_error=0; read=1 at cycle 30 → valid=0 at cycle 31.
- Send 4'b0111 with parity bit 0 (wrong; even parity requires 1) → valid=1, parallel_out=4'b0111, parity_error=1.
- 4'b1001 frame with stop bit 0, then line held low 20 cycles → frame_error pulses exactly 1 cycle at 27, valid stays 0, busy=1 until line returns high, then the next frame for 4'b0011 is received correctly.
- 1-cycle low glitch on the idle line → no state change beyond START, busy falls by cycle 3, no flags.
- Two back-to-back frames 4'b0001 then 4'b1110, read held 0 → parallel_out=4'b1110, valid=1, overrun=1. A repeat of this sequence with read=1 on the second frame's completion edge → overrun=0, valid=1.
- reset=1 at cycle 12 of a frame → all outputs 0 next cycle; the subsequent full frame 4'b0101 is received correctly.
